// File: rtl/fifo_pkg.sv
// Shared FIFO constants and status bundle, so parent blocks (e.g. the video pixel path)
// can carry all FIFO status bits as one value.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/param_fifo_if.sv
// Data, control and status bundle of param_fifo; master drives requests, slave is the FIFO.
interface param_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) ();

  localparam int AW = $clog2(DEPTH);

  logic              write;
  logic [DATA_W-1:0] data_in;
  logic              read;
  logic              flush;
  logic              clr_flags;
  logic [AW:0]       af_level;
  logic [AW:0]       ae_level;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic [AW:0]       fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_almost_full;
  logic              fifo_almost_empty;
  logic              fifo_overflow;
  logic              fifo_underflow;

  modport master (
    output write, data_in, read, flush, clr_flags, af_level, ae_level,
    input  data_out, data_valid, fifo_count, fifo_full, fifo_empty,
           fifo_almost_full, fifo_almost_empty, fifo_overflow, fifo_underflow
  );

  modport slave (
    input  write, data_in, read, flush, clr_flags, af_level, ae_level,
    output data_out, data_valid, fifo_count, fifo_full, fifo_empty,
           fifo_almost_full, fifo_almost_empty, fifo_overflow, fifo_underflow
  );

endinterface

// File: rtl/fifo_storage.sv
// DEPTH x DATA_W storage: one write port, one registered read port.
// A same-cycle read and write to one address returns the old word.
module fifo_storage
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register holds its value between reads.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO: pointer/count/flag control around fifo_storage.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic         clk,
  input  logic         reset_n,
  param_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];
  localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count;
  logic              data_valid_q, data_valid_d;
  logic              fifo_re, fifo_we;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        err_set, err_q, err_d;
  fifo_status_t      status;

  assign count = wr_ptr_q - rd_ptr_q;

  assign status.full         = (count == FULL_COUNT);
  assign status.empty        = (count == '0);
  assign status.almost_full  = (count >= bus.af_level);
  assign status.almost_empty = (count <= bus.ae_level);
  assign status.overflow     = err_q[0];
  assign status.underflow    = err_q[1];

  // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
  assign fifo_re = bus.read && !status.empty && !bus.flush;
  assign fifo_we = bus.write && !bus.flush && (!status.full || fifo_re);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    data_valid_d = fifo_re;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (fifo_we) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (fifo_re) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Bit 0: overflow (rejected write), bit 1: underflow (rejected read). Set beats clear.
  assign err_set[0] = bus.write && !fifo_we && !bus.flush;
  assign err_set[1] = bus.read  && !fifo_re && !bus.flush;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sticky
      assign err_d[gi] = err_set[gi] ? 1'b1 : (bus.clr_flags ? 1'b0 : err_q[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      data_valid_q <= 1'b0;
      err_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      data_valid_q <= data_valid_d;
      err_q        <= err_d;
    end
  end

  fifo_storage #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_storage (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (fifo_we && reset_n),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (bus.data_in),
    .re_i    (fifo_re),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  assign bus.data_out          = rd_data;
  assign bus.data_valid        = data_valid_q;
  assign bus.fifo_count        = count;
  assign bus.fifo_full         = status.full;
  assign bus.fifo_empty        = status.empty;
  assign bus.fifo_almost_full  = status.almost_full;
  assign bus.fifo_almost_empty = status.almost_empty;
  assign bus.fifo_overflow     = status.overflow;
  assign bus.fifo_underflow    = status.underflow;

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: a queue-based reference model predicts status and
// read words; a separate monitor checks every word the DUT presents.
module tb_param_fifo;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  param_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  param_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mq[$];     // reference FIFO contents
  logic [DW-1:0] sb_q[$];   // words the DUT must present, in order
  bit            m_ovf, m_unf, m_valid;
  logic [DW-1:0] m_out;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour for the inputs currently applied, evaluated before the edge.
  task automatic model_update();
    int  cnt;
    bit  re, we;
    if (!reset_n) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_valid = 0; m_out = '0;
    end else if (bus.flush) begin
      mq.delete();
      m_valid = 0;
    end else begin
      cnt = mq.size();
      re  = bus.read && (cnt > 0);
      we  = bus.write && ((cnt < DEPTH) || re);
      if (re) begin
        m_out = mq.pop_front();
        sb_q.push_back(m_out);
      end
      m_valid = re;
      if (we) mq.push_back(bus.data_in);
      if (bus.write && !we) m_ovf = 1; else if (bus.clr_flags) m_ovf = 0;
      if (bus.read && !re)  m_unf = 1; else if (bus.clr_flags) m_unf = 0;
    end
  endtask

  task automatic check_status();
    int n;
    n = mq.size();
    chk("count",     32'(bus.fifo_count), 32'(n));
    chk("full",      32'(bus.fifo_full), 32'(n == DEPTH));
    chk("empty",     32'(bus.fifo_empty), 32'(n == 0));
    chk("alm_full",  32'(bus.fifo_almost_full), 32'(n >= int'(bus.af_level)));
    chk("alm_empty", 32'(bus.fifo_almost_empty), 32'(n <= int'(bus.ae_level)));
    chk("overflow",  32'(bus.fifo_overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.fifo_underflow), 32'(m_unf));
    chk("valid",     32'(bus.data_valid), 32'(m_valid));
    if (!m_valid) chk("data_hold", 32'(bus.data_out), 32'(m_out));
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit f, input bit c);
    bus.write     = w;
    bus.data_in   = d;
    bus.read      = r;
    bus.flush     = f;
    bus.clr_flags = c;
    tick();
  endtask

  // Monitor: every presented word is matched against the scoreboard.
  initial begin
    logic [DW-1:0] exp_w;
    forever begin
      @(posedge clk);
      #1;
      if (bus.data_valid === 1'b1) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL mon_unexpected: data_out=0x%02h but no word expected", bus.data_out);
        end else begin
          exp_w = sb_q.pop_front();
          if (bus.data_out !== exp_w) begin
            bad++;
            $display("FAIL mon_data: got 0x%02h expected 0x%02h", bus.data_out, exp_w);
          end else begin
            $display("read word 0x%02h", bus.data_out);
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    bus.af_level = 5'd12;
    bus.ae_level = 5'd3;
    step(0, 8'h00, 0, 0, 0);
    step(1, 8'h55, 1, 1, 0);
    chk("rst_count", 32'(bus.fifo_count), 0);
    chk("rst_empty", 32'(bus.fifo_empty), 1);
    chk("rst_ae",    32'(bus.fifo_almost_empty), 1);
    chk("rst_dout",  32'(bus.data_out), 0);
    reset_n = 1'b1;

    // Fill 1..16, watching the threshold edges, then one write too many.
    for (int i = 1; i <= 16; i++) begin
      step(1, 8'(i), 0, 0, 0);
      if (i == 3)  chk("ae_at3", 32'(bus.fifo_almost_empty), 1);
      if (i == 4)  chk("ae_at4", 32'(bus.fifo_almost_empty), 0);
      if (i == 11) chk("af_at11", 32'(bus.fifo_almost_full), 0);
      if (i == 12) chk("af_at12", 32'(bus.fifo_almost_full), 1);
    end
    chk("full16",  32'(bus.fifo_full), 1);
    chk("count16", 32'(bus.fifo_count), 16);
    step(1, 8'd17, 0, 0, 0);
    chk("ovf17", 32'(bus.fifo_overflow), 1);

    // Drain 16 words, then a read on empty.
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    chk("unf17",   32'(bus.fifo_underflow), 1);
    chk("valid17", 32'(bus.data_valid), 0);
    step(0, 8'h00, 0, 0, 1);
    chk("clr_both", 32'({bus.fifo_overflow, bus.fifo_underflow}), 0);

    // Full FIFO with paired read/write of 0xAA.
    for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0, 0);
    for (int i = 0; i < 4; i++)  step(1, 8'hAA, 1, 0, 0);
    chk("rw_full_count", 32'(bus.fifo_count), 16);
    chk("rw_full_ovf",   32'(bus.fifo_overflow), 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0);

    // Flush with pending read, flags preserved; then overflow and clear.
    step(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 8'(8'h80 + i), 0, 0, 0);
    step(0, 8'h00, 1, 1, 0);
    chk("flush_count", 32'(bus.fifo_count), 0);
    chk("flush_empty", 32'(bus.fifo_empty), 1);
    chk("flush_valid", 32'(bus.data_valid), 0);
    chk("flush_unf",   32'(bus.fifo_underflow), 1);
    for (int i = 0; i < 17; i++) step(1, 8'(8'hC0 + i), 0, 0, 0);
    chk("ovf_set", 32'(bus.fifo_overflow), 1);
    step(0, 8'h00, 0, 0, 1);
    chk("ovf_clr", 32'(bus.fifo_overflow), 0);

    // Pointer wrap with streaming pairs, then reset mid-stream.
    step(0, 8'h00, 0, 1, 0);
    step(1, 8'($urandom), 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 8'($urandom), 1, 0, 0);
    reset_n = 1'b0;
    step(1, 8'h77, 1, 0, 0);
    chk("midrst_count", 32'(bus.fifo_count), 0);
    chk("midrst_flags", 32'({bus.fifo_overflow, bus.fifo_underflow, bus.data_valid}), 0);
    reset_n = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      bit w, r, f, c;
      if (i % 50 == 0) begin
        bus.af_level = 5'($urandom_range(0, DEPTH));
        bus.ae_level = 5'($urandom_range(0, DEPTH));
      end
      reset_n = ($urandom_range(0, 299) != 0);
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 99) < 2);
      c = !f && ($urandom_range(0, 99) < 3);
      step(w, 8'($urandom), r, f, c);
    end
    reset_n = 1'b1;
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 The block SHALL take parameter DATA_W, default 8, meaning data word width in bits (>=1).
REQ-002 The block SHALL take parameter DEPTH, default 16, meaning entry count; a power of two >=2; AW = clog2(DEPTH).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset; ports: clk input 1 (rising-edge clock), reset_n input 1 (synchronous active-low reset).
REQ-004 The block SHALL have these ports:
- write input 1: write request.
- data_in input DATA_W: write data.
- read input 1: read request.
- flush input 1: synchronous discard of contents.
- clr_flags input 1: clears sticky error flags.
- af_level input AW+1: almost-full threshold.
- ae_level input AW+1: almost-empty threshold.
- data_out output DATA_W: registered read data.
- data_valid output 1: data_out holds a newly read word.
- fifo_count output AW+1: occupancy, 0..DEPTH.
- fifo_full, fifo_empty output 1: status.
- fifo_almost_full, fifo_almost_empty output 1: threshold status.
- fifo_overflow, fifo_underflow output 1: sticky errors.

Function
REQ-005 Pointers SHALL be AW+1 bits, increment modulo 2^(AW+1), and address storage with bits [AW-1:0].
REQ-006 Occupancy SHALL be (wr_ptr - rd_ptr) mod 2^(AW+1).
- fifo_full SHALL be occupancy==DEPTH.
- fifo_empty SHALL be occupancy==0.
- All status flags SHALL be derived from registered pointers only.
REQ-007 A read SHALL be accepted (fifo_re) iff read=1, fifo_empty=0 and flush=0.
REQ-008 A write SHALL be accepted (fifo_we) iff write=1, flush=0, and either fifo_full=0 or fifo_re=1; a simultaneous read and write when full SHALL succeed with no change in count.
REQ-009 A simultaneous read and write when empty SHALL accept only the write; the read SHALL count as an underflow.
REQ-010 Read latency SHALL be 1 cycle: on fifo_re the word at rd_ptr appears on data_out next cycle with data_valid=1.
- data_valid SHALL be 0 on any cycle not following an accepted read.
- data_out SHALL hold its value while data_valid=0.
REQ-011 fifo_count SHALL change by +1 (write only), -1 (read only) or 0 (both or neither) per cycle.
REQ-012 fifo_almost_full SHALL be fifo_count >= af_level; fifo_almost_empty SHALL be fifo_count <= ae_level; both unsigned, combinational from fifo_count.
REQ-013 fifo_overflow SHALL set the cycle after write=1 with fifo_we=0 and flush=0, and hold until clr_flags; set SHALL win over a same-cycle clr_flags.
REQ-014 fifo_underflow SHALL behave the same way for read=1 with fifo_re=0 and flush=0.
REQ-015 flush=1 SHALL, next cycle:
- zero both pointers;
- force data_valid=0;
- leave data_out, the sticky flags and the storage contents unchanged.
flush SHALL override read and write in that cycle.
REQ-016 Storage SHALL be written only on fifo_we; a word SHALL be readable on the cycle after it is written.

Reset
REQ-017 While reset_n=0 at a clock edge, next cycle:
- pointers SHALL be 0, data_out 0, data_valid 0, fifo_overflow 0, fifo_underflow 0;
- hence fifo_count=0, fifo_empty=1, fifo_full=0, fifo_almost_empty=1.
REQ-018 Reset SHALL override flush, read and write, including mid-burst; storage contents need not be cleared.

Structure
REQ-019 Shared package fifo_pkg SHALL hold the default DATA_W/DEPTH constants and a status struct type (full, empty, almost_full, almost_empty, overflow, underflow) for parent blocks such as the video pixel path.
REQ-020 One sub-module, fifo_storage, SHALL contain the DEPTH x DATA_W array with one write port and one registered read port; the pointer, count and flag logic SHALL stay in param_fifo.

Verification (DATA_W=8, DEPTH=16)
REQ-021 Write 1..16 back-to-back, then a 17th write -> fifo_full=1 after 16 writes, fifo_count=16, fifo_overflow=1 the cycle after the 17th; storage still holds 1..16.
REQ-022 Read 16 words -> data_out = 1..16 in order, each 1 cycle after its read; a 17th read -> fifo_underflow=1, data_valid=0.
REQ-023 Full FIFO with read=write=1 and data_in=0xAA for 4 cycles -> fifo_count stays 16, no overflow, 0xAA appears after the 12 remaining original words.
REQ-024 af_level=12, ae_level=3, fill 0->16 -> fifo_almost_full rises at count 12; fifo_almost_empty falls at count 4.
REQ-025 Load 10 words, assert flush with read=1 -> next cycle fifo_count=0, fifo_empty=1, data_valid=0, sticky flags unchanged; clr_flags=1 with overflow set -> overflow=0 next cycle.
REQ-026 Pointer wrap: run 40 write/read pairs -> data stays in order across the wraps; reset_n=0 mid-stream -> fifo_count=0 and flags 0 the next cycle.
